// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and IF/ID pipeline register.
//
// Builds the fetch PC and drives a request/response instruction memory.
// Returned words are buffered in a small prefetch FIFO and handed to decode
// as {instruction, PC, PC+4, valid}. Decode can send back a redirect
// (takeBranch/branch_PC), a stall and a halt.
//
// Optional build macro FETCH_BYPASS_EN: when it is defined, a response that
// arrives while the FIFO is empty goes straight into IF/ID in the same cycle.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   imem_req/imem_addr    fetch request and word-aligned address
//   imem_ready            memory accepts the request this cycle
//   imem_rvalid/rdata     in-order response, at least one cycle after accept
//   stall                 decode cannot accept; IF/ID holds
//   takeBranch/branch_PC  redirect from decode
//   halt                  stop fetching; IF/ID parks on a bubble
//   *_IFID_out            instruction, PC, PC+4 and valid to decode
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | one cycle after reset, nothing requested yet
// S_RUN   | fetching normally
// S_HALTED| halt seen; no requests, IF/ID frozen on a bubble until reset

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        takeBranch,
  input  logic [31:0] branch_PC,
  input  logic        halt,
  output logic [31:0] instruction_IFID_out,
  output logic [31:0] PC_IFID_out,
  output logic [31:0] PC_plus4_IFID_out,
  output logic        valid_IFID_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      fetch_pc_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_d;
  logic [CNT_W-1:0] discard_q;

  logic [31:0]      fifo_instr_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0] fifo_wr_q, fifo_rd_q;
  logic [CNT_W-1:0] fifo_cnt_q;

  // PCs of accepted, not-yet-returned requests, in issue order
  logic [31:0]      infl_pc_q [FIFO_DEPTH];
  logic [PTR_W-1:0] infl_wr_q, infl_rd_q;

  logic [CNT_W:0] occupancy;
  logic           halt_now;
  logic           accept;
  logic           redirect;
  logic           resp_keep;
  logic           fifo_empty;
  logic           pop;
  logic           push;
  logic           bypass;

  assign occupancy  = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
  assign fifo_empty = (fifo_cnt_q == '0);
  assign imem_addr  = fetch_pc_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    halt_now = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        imem_req = !takeBranch && !halt && (occupancy < DEPTH_OCC);
        if (halt && !stall) begin
          state_d  = S_HALTED;
          halt_now = 1'b1;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // halt beats a simultaneous redirect, and a halted stage ignores redirects
  assign redirect  = takeBranch && !halt && (state_q != S_HALTED);
  assign accept    = imem_req && imem_ready;
  assign resp_keep = imem_rvalid && (discard_q == '0);

  assign pop = (state_q != S_HALTED) && !halt_now && !redirect && !stall && !fifo_empty;

`ifdef FETCH_BYPASS_EN
  assign bypass = (state_q != S_HALTED) && !halt_now && !redirect && !stall &&
                  fifo_empty && resp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_keep && !redirect && !bypass;

  // accept and response in the same cycle cancel out
  assign outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid);

  // ------------------------------------------------ fetch PC and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect) begin
        fetch_pc_q <= branch_PC;
        // every request still in flight after this cycle is stale
        discard_q  <= outstanding_d;
      end else begin
        if (accept) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (imem_rvalid && (discard_q != '0)) discard_q <= discard_q - 1'b1;
      end
    end
  end

  // ------------------------------------------------ in-flight PC queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_wr_q <= '0;
      infl_rd_q <= '0;
    end else if (redirect) begin
      infl_wr_q <= '0;
      infl_rd_q <= '0;
    end else begin
      if (accept)    infl_wr_q <= infl_wr_q + 1'b1;
      if (resp_keep) infl_rd_q <= infl_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) infl_pc_q[infl_wr_q] <= fetch_pc_q;
  end

  // ------------------------------------------------ prefetch FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else if (redirect) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) fifo_wr_q <= fifo_wr_q + 1'b1;
      if (pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[fifo_wr_q] <= imem_rdata;
      fifo_pc_q[fifo_wr_q]    <= infl_pc_q[infl_rd_q];
    end
  end

  // ------------------------------------------------ IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_IFID_out <= NOP_INSTR;
      PC_IFID_out          <= 32'd0;
      PC_plus4_IFID_out    <= 32'd4;
      valid_IFID_out       <= 1'b0;
    end else if (state_q != S_HALTED) begin
      if (halt_now || redirect) begin
        // bubbles keep the PC fields of the last instruction
        instruction_IFID_out <= NOP_INSTR;
        valid_IFID_out       <= 1'b0;
      end else if (!stall) begin
        if (pop) begin
          instruction_IFID_out <= fifo_instr_q[fifo_rd_q];
          PC_IFID_out          <= fifo_pc_q[fifo_rd_q];
          PC_plus4_IFID_out    <= fifo_pc_q[fifo_rd_q] + 32'd4;
          valid_IFID_out       <= 1'b1;
        end else if (bypass) begin
          instruction_IFID_out <= imem_rdata;
          PC_IFID_out          <= infl_pc_q[infl_rd_q];
          PC_plus4_IFID_out    <= infl_pc_q[infl_rd_q] + 32'd4;
          valid_IFID_out       <= 1'b1;
        end else begin
          instruction_IFID_out <= NOP_INSTR;
          valid_IFID_out       <= 1'b0;
        end
      end
    end
  end

endmodule
